// File: rtl/pc_gen_if.sv
// pc_gen_if: request/response bundle between the fetch-control logic and
// pc_gen. The "master" modport is the requester side (decode/execute/
// exception logic); the "slave" modport is pc_gen itself.
//
// Handshake: every *_req / *_taken / *_valid line is a level-sensitive valid
// that pc_gen samples on the falling clock edge together with its payload.
// There is no ready; "stall" is the only back-pressure. A valid sampled with
// stall = 0 is consumed on that edge. A valid sampled with stall = 1 is either
// buffered (redirect_pending rises) or dropped, and the requester is not told
// which. Exceptions are consumed on every edge regardless of stall.
interface pc_gen_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall;
  logic                exc_req;
  logic                eret_req;
  logic [PC_WIDTH-1:0] epc_in;
  logic                br_taken;
  logic [PC_WIDTH-1:0] br_target;
  logic                ret_valid;
  logic [PC_WIDTH-1:0] ret_target;
  logic                jmp_valid;
  logic [PC_WIDTH-1:0] jmp_target;
  logic                call_valid;
  logic [PC_WIDTH-1:0] call_link;
  logic [PC_WIDTH-1:0] pc_out;
  logic                redirect_pending;
  logic                ras_empty;
  logic                ras_overflow;

  modport master (
    output stall, exc_req, eret_req, epc_in, br_taken, br_target,
           ret_valid, ret_target, jmp_valid, jmp_target, call_valid, call_link,
    input  pc_out, redirect_pending, ras_empty, ras_overflow
  );

  modport slave (
    input  stall, exc_req, eret_req, epc_in, br_taken, br_target,
           ret_valid, ret_target, jmp_valid, jmp_target, call_valid, call_link,
    output pc_out, redirect_pending, ras_empty, ras_overflow
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator at the head of the IF stage.
// Holds the fetch address, steps it by INSTR_BYTES, and picks between the
// redirect sources exception > ERET > branch > return > jump > sequential.
// Redirects that arrive under stall are held in a one-entry priority buffer
// and applied when the stall releases. All state updates on the falling edge.
//
// Build option: define PC_GEN_RAS_EN to build the return-address stack that
// predicts `jr $ra` targets. Without it, returns go to ret_target, call_valid
// is ignored, ras_empty is tied 1 and ras_overflow is tied 0.
module pc_gen #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'hf0000000,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = 32'h80000180,
  parameter int                  INSTR_BYTES  = 4,
  parameter int                  RAS_DEPTH    = 4
) (
  input logic     clk,
  input logic     reset_n,
  pc_gen_if.slave bus
);

  // Buffered-redirect priority ranks; exceptions are never buffered, so the
  // exception rank only exists to document the ordering.
  typedef enum logic [2:0] {
    PRIO_NONE = 3'd0,
    PRIO_JMP  = 3'd1,
    PRIO_RET  = 3'd2,
    PRIO_BR   = 3'd3,
    PRIO_ERET = 3'd4,
    PRIO_EXC  = 3'd5
  } prio_e;

  // Architectural state
  logic [PC_WIDTH-1:0] pc_q,       pc_d;
  logic                pend_q,     pend_d;
  prio_e               pend_prio_q, pend_prio_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  // Request decode
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] ret_pred_tgt;
  prio_e               req_prio;
  logic [PC_WIDTH-1:0] req_tgt;
  logic                buffered;

  assign seq_pc = pc_q + PC_WIDTH'(INSTR_BYTES);

  // Highest-priority non-exception request this cycle and its target.
  always_comb begin
    req_prio = PRIO_NONE;
    req_tgt  = seq_pc;
    if (bus.eret_req) begin
      req_prio = PRIO_ERET;
      req_tgt  = bus.epc_in;
    end else if (bus.br_taken) begin
      req_prio = PRIO_BR;
      req_tgt  = bus.br_target;
    end else if (bus.ret_valid) begin
      req_prio = PRIO_RET;
      req_tgt  = ret_pred_tgt;
    end else if (bus.jmp_valid) begin
      req_prio = PRIO_JMP;
      req_tgt  = bus.jmp_target;
    end
  end

  // Next fetch address and pending-buffer update.
  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_prio_d = pend_prio_q;
    pend_tgt_d  = pend_tgt_q;
    buffered    = 1'b0;
    if (bus.exc_req) begin
      // Exceptions bypass the stall and flush any waiting redirect.
      pc_d        = EXC_VECTOR;
      pend_d      = 1'b0;
      pend_prio_d = PRIO_NONE;
    end else if (bus.stall) begin
      // Hold the PC; keep only the strongest redirect seen during the stall.
      if (req_prio != PRIO_NONE && (!pend_q || req_prio > pend_prio_q)) begin
        pend_d      = 1'b1;
        pend_prio_d = req_prio;
        pend_tgt_d  = req_tgt;
        buffered    = 1'b1;
      end
    end else if (pend_q) begin
      // Stall released: the buffered redirect goes unless a strictly
      // stronger request arrives on the same edge.
      pc_d        = (req_prio > pend_prio_q) ? req_tgt : pend_tgt_q;
      pend_d      = 1'b0;
      pend_prio_d = PRIO_NONE;
    end else if (req_prio != PRIO_NONE) begin
      pc_d = req_tgt;
    end else begin
      pc_d = seq_pc;
    end
  end

  // PC and pending-buffer registers.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_VECTOR;
      pend_q      <= 1'b0;
      pend_prio_q <= PRIO_NONE;
      pend_tgt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_prio_q <= pend_prio_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  assign bus.pc_out           = pc_q;
  assign bus.redirect_pending = pend_q;

`ifdef PC_GEN_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    top_q, top_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                ras_wr_en;
  logic [PTR_W-1:0]    ras_wr_idx;
  logic                ras_is_empty;
  logic                ras_accept;
  logic                do_push;
  logic                do_pop;

  assign ras_is_empty = (cnt_q == '0);
  assign ret_pred_tgt = ras_is_empty ? bus.ret_target : ras_mem[top_q];

  // The stack only moves when the call/return itself takes effect: on an
  // unstalled edge, or when this cycle's redirect went into the buffer.
  assign ras_accept = !bus.exc_req && (!bus.stall || buffered);
  assign do_push    = ras_accept && bus.call_valid;
  assign do_pop     = ras_accept && bus.ret_valid;

  // Stack pointer/count update and write-port selection.
  always_comb begin
    top_d      = top_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    ras_wr_en  = 1'b0;
    ras_wr_idx = top_q + 1'b1;
    if (do_push && do_pop && !ras_is_empty) begin
      // Return and call together: swap the top entry in place.
      ras_wr_en  = 1'b1;
      ras_wr_idx = top_q;
    end else if (do_push) begin
      // A full stack wraps onto its oldest entry and flags the loss.
      ras_wr_en  = 1'b1;
      ras_wr_idx = top_q + 1'b1;
      top_d      = top_q + 1'b1;
      if (cnt_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (do_pop && !ras_is_empty) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack pointer, occupancy and sticky overflow registers.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Stack storage; contents are don't-care until counted as valid.
  always_ff @(negedge clk) begin
    if (ras_wr_en) begin
      ras_mem[ras_wr_idx] <= bus.call_link;
    end
  end

  assign bus.ras_empty    = ras_is_empty;
  assign bus.ras_overflow = ovf_q;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_inputs;

  assign ret_pred_tgt      = bus.ret_target;
  assign unused_ras_inputs = ^{bus.call_valid, bus.call_link, buffered,
                               unused_ras_depth[0]};
  assign bus.ras_empty     = 1'b1;
  assign bus.ras_overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic for pc_gen, checked
// against a behavioural model (priority ranks, a one-slot redirect buffer and
// a bounded queue acting as the return stack). Works with and without
// PC_GEN_RAS_EN defined.
module tb_pc_gen;
  localparam logic [31:0] RESET_VECTOR = 32'hf0000000;
  localparam logic [31:0] EXC_VECTOR   = 32'h80000180;
  localparam int          RAS_DEPTH    = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  pc_gen_if #(.PC_WIDTH(32)) bus ();

  pc_gen #(
    .PC_WIDTH    (32),
    .RESET_VECTOR(RESET_VECTOR),
    .EXC_VECTOR  (EXC_VECTOR),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (RAS_DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_pend;
  int          m_pend_rank;
  logic [31:0] m_pend_tgt;
  logic [31:0] m_stack[$];
  bit          m_ovf;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_pc        = RESET_VECTOR;
    m_pend      = 1'b0;
    m_pend_rank = 0;
    m_pend_tgt  = '0;
    m_stack.delete();
    m_ovf       = 1'b0;
  endtask

  function automatic bit model_empty();
`ifdef PC_GEN_RAS_EN
    return m_stack.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  // Apply one falling edge to the model using the inputs currently driven.
  task automatic model_edge();
    int          rank;
    logic [31:0] tgt;
    logic [31:0] ret_pred;
    bit          acc;
    ret_pred = bus.ret_target;
`ifdef PC_GEN_RAS_EN
    if (m_stack.size() > 0) ret_pred = m_stack[m_stack.size()-1];
`endif
    rank = 0;
    tgt  = '0;
    if      (bus.eret_req)  begin rank = 4; tgt = bus.epc_in;     end
    else if (bus.br_taken)  begin rank = 3; tgt = bus.br_target;  end
    else if (bus.ret_valid) begin rank = 2; tgt = ret_pred;       end
    else if (bus.jmp_valid) begin rank = 1; tgt = bus.jmp_target; end
    acc = 1'b0;
    if (bus.exc_req) begin
      m_pc   = EXC_VECTOR;
      m_pend = 1'b0;
    end else if (bus.stall) begin
      if (rank > 0 && (!m_pend || rank > m_pend_rank)) begin
        m_pend      = 1'b1;
        m_pend_rank = rank;
        m_pend_tgt  = tgt;
        acc         = 1'b1;
      end
    end else if (m_pend) begin
      m_pc   = (rank > m_pend_rank) ? tgt : m_pend_tgt;
      m_pend = 1'b0;
      acc    = 1'b1;
    end else begin
      m_pc = (rank > 0) ? tgt : m_pc + 32'd4;
      acc  = 1'b1;
    end
`ifdef PC_GEN_RAS_EN
    if (acc) begin
      if (bus.call_valid && bus.ret_valid && m_stack.size() > 0) begin
        m_stack[m_stack.size()-1] = bus.call_link;
      end else if (bus.call_valid) begin
        m_stack.push_back(bus.call_link);
        if (m_stack.size() > RAS_DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
      end else if (bus.ret_valid && m_stack.size() > 0) begin
        void'(m_stack.pop_back());
      end
    end
`else
    if (acc && bus.call_valid) m_ovf = 1'b0;
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.stall      = 1'b0;
    bus.exc_req    = 1'b0;
    bus.eret_req   = 1'b0;
    bus.epc_in     = '0;
    bus.br_taken   = 1'b0;
    bus.br_target  = '0;
    bus.ret_valid  = 1'b0;
    bus.ret_target = '0;
    bus.jmp_valid  = 1'b0;
    bus.jmp_target = '0;
    bus.call_valid = 1'b0;
    bus.call_link  = '0;
  endtask

  // One clock: model follows the edge, then outputs settle 1 unit later.
  task automatic cycle();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    model_reset();
    #12;
    reset_n = 1'b1;
    #1;
    checks++; if (bus.pc_out !== RESET_VECTOR) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_out, RESET_VECTOR); end
    checks++; if (bus.redirect_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", bus.redirect_pending); end
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL reset_ras_empty got=%b exp=1", bus.ras_empty); end
    checks++; if (bus.ras_overflow !== 1'b0) begin failures++; $display("FAIL reset_ras_overflow got=%b exp=0", bus.ras_overflow); end
    for (int i = 1; i <= 3; i++) begin
      logic [31:0] exp_pc;
      exp_pc = RESET_VECTOR + 32'(4 * i);
      cycle();
      checks++; if (bus.pc_out !== exp_pc) begin failures++; $display("FAIL seq_step%0d got=%h exp=%h", i, bus.pc_out, exp_pc); end
    end
  endtask

  task automatic test_branch_jump();
    idle();
    bus.br_taken   = 1'b1; bus.br_target  = 32'h00400020;
    bus.jmp_valid  = 1'b1; bus.jmp_target = 32'h00400100;
    cycle();
    checks++; if (bus.pc_out !== 32'h00400020) begin failures++; $display("FAIL br_over_jmp got=%h exp=00400020", bus.pc_out); end
    idle();
    cycle();
    checks++; if (bus.pc_out !== 32'h00400024) begin failures++; $display("FAIL br_next got=%h exp=00400024", bus.pc_out); end
  endtask

  task automatic test_stall_buffer();
    idle();
    bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h00001000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (bus.pc_out !== 32'h00400024) begin failures++; $display("FAIL stall_hold%0d got=%h exp=00400024", i, bus.pc_out); end
      checks++; if (bus.redirect_pending !== 1'b1) begin failures++; $display("FAIL stall_pending%0d got=%b exp=1", i, bus.redirect_pending); end
      idle();
      bus.stall = 1'b1;
    end
    idle();
    cycle();
    checks++; if (bus.pc_out !== 32'h00001000) begin failures++; $display("FAIL release_pc got=%h exp=00001000", bus.pc_out); end
    checks++; if (bus.redirect_pending !== 1'b0) begin failures++; $display("FAIL release_pending got=%b exp=0", bus.redirect_pending); end
  endtask

  task automatic test_stall_priority();
    logic [31:0] held;
    held = m_pc;
    idle(); bus.stall = 1'b1; bus.jmp_valid = 1'b1; bus.jmp_target = 32'h00002000; cycle();
    idle(); bus.stall = 1'b1; bus.br_taken  = 1'b1; bus.br_target  = 32'h00003000; cycle();
    idle(); bus.stall = 1'b1; bus.jmp_valid = 1'b1; bus.jmp_target = 32'h00004000; cycle();
    checks++; if (bus.pc_out !== held) begin failures++; $display("FAIL prio_hold got=%h exp=%h", bus.pc_out, held); end
    idle();
    cycle();
    checks++; if (bus.pc_out !== 32'h00003000) begin failures++; $display("FAIL prio_release got=%h exp=00003000", bus.pc_out); end
    // Exception under stall with something pending: applies at once and flushes.
    idle(); bus.stall = 1'b1; bus.jmp_valid = 1'b1; bus.jmp_target = 32'h00005000; cycle();
    idle(); bus.stall = 1'b1; bus.exc_req = 1'b1; cycle();
    checks++; if (bus.pc_out !== EXC_VECTOR) begin failures++; $display("FAIL exc_in_stall got=%h exp=%h", bus.pc_out, EXC_VECTOR); end
    checks++; if (bus.redirect_pending !== 1'b0) begin failures++; $display("FAIL exc_flush got=%b exp=0", bus.redirect_pending); end
    idle();
    cycle();
    checks++; if (bus.pc_out !== EXC_VECTOR + 32'd4) begin failures++; $display("FAIL exc_after got=%h exp=%h", bus.pc_out, EXC_VECTOR + 32'd4); end
  endtask

  task automatic test_release_rules();
    // Stronger same-edge request beats the buffered one.
    idle(); bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h00006000; cycle();
    idle(); bus.eret_req = 1'b1; bus.epc_in = 32'h00007000; cycle();
    checks++; if (bus.pc_out !== 32'h00007000) begin failures++; $display("FAIL release_override got=%h exp=00007000", bus.pc_out); end
    checks++; if (bus.redirect_pending !== 1'b0) begin failures++; $display("FAIL override_pending got=%b exp=0", bus.redirect_pending); end
    // Equal priority under stall is dropped; weaker at release loses.
    idle(); bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h00008000; cycle();
    idle(); bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h00009000; cycle();
    idle(); bus.jmp_valid = 1'b1; bus.jmp_target = 32'h0000a000; cycle();
    checks++; if (bus.pc_out !== 32'h00008000) begin failures++; $display("FAIL equal_dropped got=%h exp=00008000", bus.pc_out); end
  endtask

  task automatic test_wrap();
    idle(); bus.jmp_valid = 1'b1; bus.jmp_target = 32'hfffffffc; cycle();
    checks++; if (bus.pc_out !== 32'hfffffffc) begin failures++; $display("FAIL wrap_jump got=%h exp=fffffffc", bus.pc_out); end
    idle(); cycle();
    checks++; if (bus.pc_out !== 32'h00000000) begin failures++; $display("FAIL wrap_seq got=%h exp=00000000", bus.pc_out); end
  endtask

  task automatic test_ras();
    logic [31:0] links [5];
    links[0] = 32'h0000a008; links[1] = 32'h0000b008; links[2] = 32'h0000c008;
    links[3] = 32'h0000d008; links[4] = 32'h0000e008;
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.call_valid = 1'b1; bus.call_link = links[i];
      bus.jmp_valid  = 1'b1; bus.jmp_target = 32'h00500000 + 32'(i * 64);
      cycle();
    end
`ifdef PC_GEN_RAS_EN
    checks++; if (bus.ras_overflow !== 1'b1) begin failures++; $display("FAIL ras_overflow got=%b exp=1", bus.ras_overflow); end
    checks++; if (bus.ras_empty !== 1'b0) begin failures++; $display("FAIL ras_full_empty got=%b exp=0", bus.ras_empty); end
    for (int i = 4; i >= 1; i--) exp_q.push_back(links[i]);
    exp_q.push_back(32'h0000dead);
`else
    checks++; if (bus.ras_overflow !== 1'b0) begin failures++; $display("FAIL ras_overflow_tied got=%b exp=0", bus.ras_overflow); end
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL ras_empty_tied got=%b exp=1", bus.ras_empty); end
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h0000dead);
`endif
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_pc;
      logic        exp_empty;
      idle();
      bus.ret_valid = 1'b1; bus.ret_target = 32'h0000dead;
      cycle();
      exp_pc = exp_q.pop_front();
`ifdef PC_GEN_RAS_EN
      exp_empty = (i >= 3);
`else
      exp_empty = 1'b1;
`endif
      checks++; if (bus.pc_out !== exp_pc) begin failures++; $display("FAIL ras_ret%0d got=%h exp=%h", i, bus.pc_out, exp_pc); end
      checks++; if (bus.ras_empty !== exp_empty) begin failures++; $display("FAIL ras_empty%0d got=%b exp=%b", i, bus.ras_empty, exp_empty); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.stall      = ($urandom_range(0, 2) == 0);
      bus.exc_req    = ($urandom_range(0, 15) == 0);
      bus.eret_req   = ($urandom_range(0, 9) == 0);
      bus.epc_in     = $urandom & 32'hfffffffc;
      bus.br_taken   = ($urandom_range(0, 4) == 0);
      bus.br_target  = $urandom & 32'hfffffffc;
      bus.ret_valid  = ($urandom_range(0, 4) == 0);
      bus.ret_target = $urandom & 32'hfffffffc;
      bus.jmp_valid  = ($urandom_range(0, 3) == 0);
      bus.jmp_target = $urandom & 32'hfffffffc;
      bus.call_valid = ($urandom_range(0, 3) == 0);
      bus.call_link  = $urandom & 32'hfffffffc;
      if (bus.call_valid && bus.ret_valid && m_stack.size() == 0) bus.ret_valid = 1'b0;
      cycle();
      checks++; if (bus.pc_out !== m_pc) begin failures++; $display("FAIL rand_pc[%0d] got=%h exp=%h", n, bus.pc_out, m_pc); end
      checks++; if (bus.redirect_pending !== m_pend) begin failures++; $display("FAIL rand_pending[%0d] got=%b exp=%b", n, bus.redirect_pending, m_pend); end
      checks++; if (bus.ras_empty !== model_empty()) begin failures++; $display("FAIL rand_ras_empty[%0d] got=%b exp=%b", n, bus.ras_empty, model_empty()); end
      checks++; if (bus.ras_overflow !== m_ovf) begin failures++; $display("FAIL rand_ras_overflow[%0d] got=%b exp=%b", n, bus.ras_overflow, m_ovf); end
    end
  endtask

  task automatic test_async_reset();
    idle();
    bus.stall = 1'b1; bus.call_valid = 1'b1; bus.call_link = 32'h00000abc;
    bus.br_taken = 1'b1; bus.br_target = 32'h00001234;
    cycle();
    checks++; if (bus.redirect_pending !== 1'b1) begin failures++; $display("FAIL arst_setup_pending got=%b exp=1", bus.redirect_pending); end
    // Mid-cycle, well away from either clock edge.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.pc_out !== RESET_VECTOR) begin failures++; $display("FAIL arst_pc got=%h exp=%h", bus.pc_out, RESET_VECTOR); end
    checks++; if (bus.redirect_pending !== 1'b0) begin failures++; $display("FAIL arst_pending got=%b exp=0", bus.redirect_pending); end
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL arst_ras_empty got=%b exp=1", bus.ras_empty); end
    checks++; if (bus.ras_overflow !== 1'b0) begin failures++; $display("FAIL arst_ras_overflow got=%b exp=0", bus.ras_overflow); end
    idle();
    @(posedge clk);
    reset_n = 1'b1;
    cycle();
    checks++; if (bus.pc_out !== RESET_VECTOR + 32'd4) begin failures++; $display("FAIL arst_resume got=%h exp=%h", bus.pc_out, RESET_VECTOR + 32'd4); end
    checks++; if (bus.redirect_pending !== 1'b0) begin failures++; $display("FAIL arst_resume_pending got=%b exp=0", bus.redirect_pending); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_branch_jump();
    test_stall_buffer();
    test_stall_priority();
    test_release_rules();
    test_wrap();
    test_ras();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator, the successor of the single-register PC. It holds the fetch address and advances it sequentially. It selects between prioritised redirect sources: exception, ERET, branch, return and jump. A redirect that arrives while fetch is stalled is buffered and applied when the stall releases. An optional return-address stack predicts `jr $ra` targets. It sits at the head of the IF stage and drives the instruction-memory address.

## Interface
- `PC_WIDTH`, 32: width of every address bus.
- `RESET_VECTOR`, 32'hf0000000: loader address loaded on reset.
- `EXC_VECTOR`, 32'h80000180: exception entry address.
- `INSTR_BYTES`, 4: sequential increment.
- `RAS_DEPTH`, 4: return-stack entries, power of two, ≥2 (used only with `PC_GEN_RAS_EN`).

Ports:
- `clk` in 1: clock; all state updates on the falling edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: holds `pc_out` (exceptions excepted).
- `exc_req` in 1: exception; target `EXC_VECTOR`.
- `eret_req` in 1: ERET; target `epc_in`.
- `epc_in` in PC_WIDTH: ERET target.
- `br_taken` in 1: taken branch; target `br_target`.
- `br_target` in PC_WIDTH: branch target.
- `ret_valid` in 1: `jr $ra` resolved/decoded.
- `ret_target` in PC_WIDTH: architectural return address (fallback target).
- `jmp_valid` in 1: j/jal/jr (non-return); target `jmp_target`.
- `jmp_target` in PC_WIDTH: jump target.
- `call_valid` in 1: jal/jalr; push `call_link` onto the RAS.
- `call_link` in PC_WIDTH: link value (PC+8).
- `pc_out` out PC_WIDTH: current fetch address.
- `redirect_pending` out 1: a buffered redirect is waiting.
- `ras_empty` out 1: RAS holds no entries.
- `ras_overflow` out 1: sticky; a push has overwritten the oldest entry.

## Operation
- Priority, highest first: `exc_req` > `eret_req` > `br_taken` > `ret_valid` > `jmp_valid` > sequential (`pc_out + INSTR_BYTES`, modulo 2^PC_WIDTH, so the address wraps).
- When `stall` = 0 and nothing is pending: `pc_out` loads the highest-priority request target, or the sequential value.
- Exception during stall: it is applied immediately. It also clears the pending buffer.
- Other request during stall, pending buffer empty: the target and its priority are latched and `redirect_pending` = 1. `pc_out` holds.
- Request during stall, buffer full: the buffer is overwritten only if the new request has strictly higher priority. Otherwise the new request is dropped.
- When `stall` falls with a redirect pending:
  - `pc_out` loads the buffered target.
  - The buffer clears.
  - A same-cycle new request with strictly higher priority wins instead.
- RAS (only with `PC_GEN_RAS_EN`):
  - Circular buffer with a top pointer and a saturating count, 0..RAS_DEPTH.
  - Push and pop occur only in cycles where the request is accepted: `stall` = 0, or the request was buffered.
  - Push when full: overwrites the oldest entry, the pointer wraps, the count stays at RAS_DEPTH, and `ras_overflow` is set.
  - Pop when empty: the target is `ret_target`, and there is no state change.
  - `call_valid` and `ret_valid` in the same cycle: the top entry is replaced with `call_link` (pop+push), and the count is unchanged.
  - Predicted return target: the top entry if non-empty, otherwise `ret_target`.
- Exceptions do not alter the RAS.

## Timing
- Reset (asynchronous, `reset_n` = 0):
  - `pc_out` = RESET_VECTOR.
  - `redirect_pending` = 0.
  - `ras_empty` = 1.
  - `ras_overflow` = 0.
  - Pointer and count = 0.
- Reset asserted mid-stall or with a redirect pending: all buffered state is discarded.
- Latency: a request sampled at falling edge n appears on `pc_out` right after edge n, with one register stage.
- `redirect_pending` rises after the edge that buffered the request. It falls after the edge that applies or discards it.
- `ras_empty`/`ras_overflow` reflect state after the current edge. There is no combinational path from inputs to `pc_out`.

## Configuration
- `PC_GEN_RAS_EN` defined: RAS logic is built as described above.
- `PC_GEN_RAS_EN` undefined:
  - No RAS storage.
  - `ret_valid` redirects to `ret_target` at the same priority.
  - `call_valid` is ignored.
  - `ras_empty` is tied 1 and `ras_overflow` is tied 0.

## Test plan
- Reset then 3 free-running cycles: `pc_out` steps f0000000 → f0000004 → f0000008 → f000000c.
- Branch to 0x00400020 with a same-cycle jump to 0x00400100: `pc_out` = 0x00400020. The next cycle is 0x00400024.
- `stall` = 1, branch to 0x1000; stall held 3 cycles: `pc_out` holds and `redirect_pending` = 1. After the stall drops: `pc_out` = 0x1000 and pending = 0.
- Under stall: jump to 0x2000, then branch to 0x3000, then jump to 0x4000. The release gives `pc_out` = 0x3000. Then `exc_req` under stall gives `pc_out` = 0x80000180 immediately and pending = 0.
- RAS_DEPTH = 4, `PC_GEN_RAS_EN`:
  - Five calls with links A..E set `ras_overflow`.
  - Five returns with `ret_target` = 0xdead give E, D, C, B, then 0xdead.
  - `ras_empty` = 1 after the fourth return.
- Assert `reset_n` = 0 asynchronously mid-stall with a pending redirect: `pc_out` = f0000000 without waiting for a clock edge, and all flags are clear.
